// File: rtl/serial_pkg.sv
// Shared constants for the serial feeder and the detector bench that consumes its stream.
package serial_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_GAP   = ST_GAP
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_GAP   = 2;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Up-counter that stops at TC; tc flags the terminal value.
module mod_counter #(
    parameter int unsigned W  = 1,
    parameter int unsigned TC = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(TC));

endmodule

// File: rtl/serial_frame_feeder.sv
// Parallel-to-serial feeder: one word per handshake, one bit per clock, idle gap between frames.
module serial_frame_feeder
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned GAP       = DEFAULT_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned BIT_W  = cnt_width(WIDTH);
    localparam int unsigned GAP_W  = cnt_width(GAP + 1);
    localparam int unsigned GAP_TC = (GAP > 0) ? GAP - 1 : 0;

    state_t           state;
    state_t           state_nxt;
    logic             frame_done_nxt;
    logic [WIDTH-1:0] shreg;
    logic             accept;
    logic             bit_tc;
    logic             gap_tc;

    assign accept = valid_in && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        frame_done_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid_in) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_tc) begin
                    frame_done_nxt = 1'b1;
                    state_nxt      = (GAP > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_tc) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shift toward the output end with zero fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= data_in;
        end else if (state == S_SHIFT) begin
            if (MSB_FIRST) shreg <= {shreg[WIDTH-2:0], 1'b0};
            else           shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
    end

    mod_counter #(.W(BIT_W), .TC(WIDTH - 1)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state != S_SHIFT),
        .en  (state == S_SHIFT),
        .tc  (bit_tc)
    );

    mod_counter #(.W(GAP_W), .TC(GAP_TC)) u_gap_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state != S_GAP),
        .en  (state == S_GAP),
        .tc  (gap_tc)
    );

    assign ready_out  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign bit_valid  = (state == S_SHIFT);
    assign serial_out = bit_valid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

endmodule

// File: doc/serial_frame_feeder.md
# serial_frame_feeder

Parallel-to-serial front end that produces the single-bit `din` stream consumed by the serial Mealy sequence detector.
- Accepts one WIDTH-bit word per valid/ready handshake.
- Shifts the word out one bit per clock, with a qualifying `bit_valid` strobe.
- Inserts a programmable idle gap (line held low) between frames.
- Pulses `frame_done` once each frame has been fully transmitted.

## Interface
- WIDTH, 8, word/frame length in bits; legal range 2..32
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
- GAP, 2, low idle cycles after each frame; legal range 0..15

- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- data_in  input  WIDTH  parallel word; must be held stable while `valid_in`=1 and `ready_out`=0
- valid_in  input  1  upstream offers `data_in`
- ready_out  output  1  block can accept a word this cycle
- serial_out  output  1  serial bit; connects to the detector's `din`
- bit_valid  output  1  `serial_out` carries a frame bit this cycle
- busy  output  1  frame in progress (SHIFT or GAP)
- frame_done  output  1  one-cycle pulse after the last bit of a frame

## Operation
- States: IDLE, SHIFT, GAP.
- **IDLE**
  - `ready_out`=1.
  - Handshake (`valid_in`&`ready_out` at an edge): `shreg`<=`data_in`, `bit_cnt`<=0, go to SHIFT.
  - `valid_in` low: stay in IDLE.
- **SHIFT**
  - `serial_out` = `shreg[WIDTH-1]` if MSB_FIRST, else `shreg[0]`.
  - `bit_valid`=1, `busy`=1, `ready_out`=0.
  - Each edge: shift by one toward the output end, zero-fill, `bit_cnt`++.
  - When `bit_cnt`==WIDTH-1 at an edge: go to GAP with `gap_cnt`<=0 if GAP>0, else go to IDLE. `frame_done`<=1 at that same edge.
- **GAP**
  - `serial_out`=0, `bit_valid`=0, `busy`=1, `ready_out`=0.
  - `gap_cnt`++ each edge; when `gap_cnt`==GAP-1, go to IDLE.
- `frame_done` is registered; it is high for exactly one cycle and 0 otherwise.
- `serial_out` is 0 in IDLE and GAP.
- `valid_in` outside IDLE is ignored; no data is captured and no buffering is performed.
- Counter widths: `bit_cnt` is $clog2(WIDTH) bits; `gap_cnt` is max(1,$clog2(GAP+1)) bits. Neither counter ever wraps past its terminal value.
- Outputs other than `frame_done` are decoded only from registered state, `shreg` and counters, so they are glitch-free relative to `clk`.

## Timing
- Reset values after any edge with `rst`=1:
  - state IDLE; `ready_out`=1, `serial_out`=0, `bit_valid`=0, `busy`=0, `frame_done`=0.
  - `shreg` and counters cleared.
- `rst` has priority over every other event.
- Reset mid-frame aborts the frame: no further bits and no `frame_done`.
- Handshake at edge E0:
  - Bit 1 appears in cycle 1, i.e. after E0. Latency is 1 cycle.
  - Bit k appears in cycle k; the last bit is in cycle WIDTH.
  - `frame_done` is high in cycle WIDTH+1.
  - GAP cycles occupy WIDTH+1 .. WIDTH+GAP.
  - `ready_out` returns to 1 in cycle WIDTH+GAP+1.
- Minimum frame period is WIDTH+GAP+1 cycles, because IDLE always lasts at least one cycle.
- GAP=0: `frame_done` and `ready_out` are both high in cycle WIDTH+1, and a new handshake is legal at that edge.
- `rst` and `valid_in` high together: reset wins and the word is not accepted.

## Structure
- Shared package `serial_pkg`:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2.
  - the default WIDTH and GAP values, so the detector bench and the feeder agree.
- Sub-module `mod_counter`:
  - parameterised terminal count, with synchronous clear, enable, and a `tc` output.
  - instantiated twice, once for bits and once for gap.

## Test plan
- WIDTH=8, MSB_FIRST=1, GAP=2; send 0xA5 at E0:
  - `serial_out` = 1,0,1,0,0,1,0,1 in cycles 1..8 with `bit_valid`=1.
  - `frame_done`=1 in cycle 9 only.
  - `ready_out`=1 again in cycle 11.
- MSB_FIRST=0; send 0x01: `serial_out`=1 in cycle 1, then 0 in cycles 2..8.
- Back-to-back with `valid_in` held high for 0x0F then 0xF0, GAP=0:
  - 8 bits 0,0,0,0,1,1,1,1, then one IDLE cycle, then 1,1,1,1,0,0,0,0.
  - Period is 9 cycles.
- `valid_in` pulsed during SHIFT/GAP with 0xFF:
  - not accepted; the current frame completes unchanged.
  - `ready_out` stays 0 until IDLE.
- `rst` asserted in cycle 4 of a frame:
  - in the next cycle, all outputs are at their reset values.
  - no `frame_done`; a new word is accepted immediately.
- Feed 0x33 to the detector with GAP=2 and compare `dout` against the detector's golden model.
